// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one SDRAM controller port among NUM_REQ engines
// Define ARB_HOLD_LIMIT_EN to force a release after HOLD_LIMIT accepted commands per grant.
module sdram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WID   = 5,
   parameter int DATA_WID   = 21,
   parameter int MAX_PEND   = 4,
   parameter int HOLD_LIMIT = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           i_m_read,
   input  logic [NUM_REQ-1:0]           i_m_write,
   input  logic [NUM_REQ*ADDR_WID-1:0]  i_m_address,
   input  logic [NUM_REQ*DATA_WID-1:0]  i_m_writedata,
   output logic [NUM_REQ-1:0]           o_m_waitrequest,
   output logic [NUM_REQ-1:0]           o_m_readdatavalid,
   output logic [DATA_WID-1:0]          o_m_readdata,
   output logic                         o_sdram_read,
   output logic                         o_sdram_write,
   output logic [ADDR_WID-1:0]          o_sdram_address,
   output logic [DATA_WID-1:0]          o_sdram_writedata,
   input  logic                         i_sdram_waitrequest,
   input  logic                         i_sdram_readdatavalid,
   input  logic [DATA_WID-1:0]          i_sdram_readdata,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic                         o_err_spurious
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = $clog2(MAX_PEND + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

   state_t             state;
   logic [IW-1:0]      ptr, owner, win, cand;
   logic [PW-1:0]      pending, pending_nxt;
   logic [NUM_REQ-1:0] req;
   logic               own_rd, own_wr, own_active, blocked, hold_hit, rd_acc, rd_ret;

   assign req = i_m_read | i_m_write;

   always_comb begin
      owner = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (o_grant[k]) owner = IW'(k);
   end

   // Scan downward so the candidate closest to ptr is the last one written.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = IW'((int'(ptr) + i) % NUM_REQ);
         if (req[cand]) win = cand;
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(HOLD_LIMIT + 1);
   logic [HW-1:0] hold_cnt;

   assign hold_hit = (hold_cnt == HW'(HOLD_LIMIT));

   always_ff @(posedge clk) begin
      if (!reset || state != S_GRANT)
         hold_cnt <= '0;
      else if ((o_sdram_read | o_sdram_write) & ~i_sdram_waitrequest)
         hold_cnt <= hold_cnt + 1'b1;
   end
`else
   assign hold_hit = (HOLD_LIMIT < 0);
`endif

   assign own_rd     = i_m_read[owner];
   assign own_wr     = i_m_write[owner];
   assign own_active = (state == S_GRANT) & (own_rd | own_wr) & ~hold_hit;
   assign blocked    = own_rd & (pending == PMAX);

   assign o_sdram_read      = own_active & own_rd & ~blocked;
   assign o_sdram_write     = own_active & own_wr;
   assign o_sdram_address   = i_m_address[owner*ADDR_WID +: ADDR_WID];
   assign o_sdram_writedata = i_m_writedata[owner*DATA_WID +: DATA_WID];
   assign o_m_readdata      = i_sdram_readdata;

   assign rd_acc      = o_sdram_read & ~i_sdram_waitrequest;
   assign rd_ret      = i_sdram_readdatavalid & (pending != '0);
   assign pending_nxt = pending + PW'(rd_acc) - PW'(rd_ret);

   always_comb begin
      o_m_waitrequest = '1;
      if (own_active) o_m_waitrequest[owner] = i_sdram_waitrequest | blocked;
      o_m_readdatavalid = o_grant & {NUM_REQ{rd_ret}};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         o_grant        <= '0;
         pending        <= '0;
         ptr            <= '0;
         o_err_spurious <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (i_sdram_readdatavalid && pending == '0) o_err_spurious <= 1'b1;
         case (state)
            S_IDLE:
               if (|req) begin
                  o_grant <= NUM_REQ'(1) << win;
                  ptr     <= (win == LAST) ? '0 : win + 1'b1;
                  state   <= S_GRANT;
               end
            S_GRANT:
               if (!own_active) begin
                  if (pending_nxt == '0) begin
                     state   <= S_IDLE;
                     o_grant <= '0;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            S_DRAIN:
               if (pending_nxt == '0) begin
                  state   <= S_IDLE;
                  o_grant <= '0;
               end
            default: begin
               state   <= S_IDLE;
               o_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed bench for sdram_port_arbiter
// Engine/controller model runs beside the directed sequence; expected values are hand-computed.
module tb_sdram_port_arbiter;

   localparam int NR = 4, AW = 5, DW = 21, LAT = 10;
   localparam logic [AW-1:0] A0 = 5'h07, A1 = 5'h03, A2 = 5'h11, A3 = 5'h1C;
   localparam logic [DW-1:0] D0 = 21'h00F0F, D1 = 21'h0ABCD, D2 = 21'h15555, D3 = 21'h1AAAA;

   logic clk = 1'b0;
   logic reset;
   logic [NR-1:0]    m_read, m_write, m_wait, m_rdv, grant;
   logic [NR*AW-1:0] m_addr;
   logic [NR*DW-1:0] m_wdata;
   logic [DW-1:0]    m_rdata, sd_wdata, sd_rdata;
   logic [AW-1:0]    sd_addr;
   logic             sd_read, sd_write, sd_wait, sd_rdv, mdl_rdv, force_rdv, err;

   assign m_addr  = {A3, A2, A1, A0};
   assign m_wdata = {D3, D2, D1, D0};
   assign sd_rdv  = mdl_rdv | force_rdv;

   always #5 clk = ~clk;

   sdram_port_arbiter dut (
      .clk(clk), .reset(reset),
      .i_m_read(m_read), .i_m_write(m_write), .i_m_address(m_addr), .i_m_writedata(m_wdata),
      .o_m_waitrequest(m_wait), .o_m_readdatavalid(m_rdv), .o_m_readdata(m_rdata),
      .o_sdram_read(sd_read), .o_sdram_write(sd_write), .o_sdram_address(sd_addr),
      .o_sdram_writedata(sd_wdata), .i_sdram_waitrequest(sd_wait),
      .i_sdram_readdatavalid(sd_rdv), .i_sdram_readdata(sd_rdata),
      .o_grant(grant), .o_err_spurious(err)
   );

   int rd_req[NR], wr_req[NR];
   int rd_done[NR], wr_done[NR], rdv_cnt[NR];
   int acc_cnt, ret_cnt, max_out, cyc;
   int due_q[$];
   logic [AW-1:0] ra_q[$], waddr_q[$];
   logic [DW-1:0] wdata_q[$];
   logic [NR-1:0] gq[$];
   logic [NR-1:0] last_grant;
   int n_checks, n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR-1:0] gat(input int i);
      return (i < gq.size()) ? gq[i] : '0;
   endfunction

   function automatic logic [AW-1:0] wat(input int i);
      return (i < waddr_q.size()) ? waddr_q[i] : '0;
   endfunction

   function automatic logic [DW-1:0] dat(input int i);
      return (i < wdata_q.size()) ? wdata_q[i] : '0;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Engines issue their queued commands; controller returns reads LAT cycles after acceptance.
   initial begin
      m_read = '0; m_write = '0; mdl_rdv = 1'b0; sd_rdata = '0; last_grant = '0;
      acc_cnt = 0; ret_cnt = 0; max_out = 0; cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int k = 0; k < NR; k++) begin
            m_read[k]  = rd_done[k] < rd_req[k];
            m_write[k] = !m_read[k] && (wr_done[k] < wr_req[k]);
         end
         mdl_rdv = 1'b0;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mdl_rdv  = 1'b1;
            sd_rdata = 21'h1F000 | DW'(ra_q[0]);
            void'(due_q.pop_front());
            void'(ra_q.pop_front());
         end
         @(negedge clk);
         #4;
         for (int k = 0; k < NR; k++) begin
            if (m_read[k] && !m_wait[k]) rd_done[k]++;
            if (m_write[k] && !m_wait[k]) wr_done[k]++;
            if (m_rdv[k]) rdv_cnt[k]++;
         end
         if (sd_read && !sd_wait) begin
            acc_cnt++;
            due_q.push_back(cyc + LAT);
            ra_q.push_back(sd_addr);
         end
         if (sd_write && !sd_wait) begin
            waddr_q.push_back(sd_addr);
            wdata_q.push_back(sd_wdata);
         end
         if (sd_rdv) ret_cnt++;
         if (acc_cnt - ret_cnt > max_out) max_out = acc_cnt - ret_cnt;
         if (grant != last_grant && grant != '0) gq.push_back(grant);
         last_grant = grant;
      end
   end

   initial begin
      int t, p, gb, wb, ab, r0, ro, r2, r3;
      n_checks = 0; n_fail = 0;
      reset = 1'b0; sd_wait = 1'b1; force_rdv = 1'b0;
      for (int k = 0; k < NR; k++) begin
         rd_req[k] = 1; wr_req[k] = 0;
      end

      // reset held with all engines requesting, then first grant
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_wait", 32'(m_wait), 32'hF);
      check_eq("rst_sdram_read", 32'(sd_read), 32'h0);
      check_eq("rst_err", 32'(err), 32'h0);
      reset = 1'b1;
      tick();
      check_eq("first_grant", 32'(grant), 32'h1);
      check_eq("first_read_fwd", 32'(sd_read), 32'h1);
      check_eq("first_addr", 32'(sd_addr), 32'(A0));
      check_eq("first_wait_stall", 32'(m_wait), 32'hF);
      gb = 0;
      sd_wait = 1'b0;
      for (t = 0; t < 200 && !(ret_cnt == 4 && grant == '0); t++) tick();
      check_eq("t1_done", 32'(ret_cnt == 4 && grant == '0), 32'h1);
      for (int i = 0; i < 4; i++) check_eq("t1_rr_order", 32'(gat(gb + i)), 32'(1 << i));

      // two single writes from engines 1 and 2
      gb = gq.size(); wb = waddr_q.size();
      wr_req[1] += 1; wr_req[2] += 1;
      for (t = 0; t < 50 && !(wr_done[1] == 1 && wr_done[2] == 1 && grant == '0); t++) tick();
      check_eq("t2_done", 32'(wr_done[1] == 1 && wr_done[2] == 1 && grant == '0), 32'h1);
      check_eq("t2_grant0", 32'(gat(gb)), 32'h2);
      check_eq("t2_grant1", 32'(gat(gb + 1)), 32'h4);
      check_eq("t2_nwrites", 32'(waddr_q.size() - wb), 32'h2);
      check_eq("t2_addr0", 32'(wat(wb)), 32'h03);
      check_eq("t2_data0", 32'(dat(wb)), 32'h0ABCD);
      check_eq("t2_addr1", 32'(wat(wb + 1)), 32'h11);
      check_eq("t2_data1", 32'(dat(wb + 1)), 32'h15555);

      // six back-to-back reads against a MAX_PEND of 4
      ab = acc_cnt; r0 = rdv_cnt[0]; ro = rdv_cnt[1] + rdv_cnt[2] + rdv_cnt[3];
      rd_req[0] += 6;
      for (t = 0; t < 50 && !m_rdv[0]; t++) tick();
      check_eq("t3_first_ret", 32'(m_rdv[0]), 32'h1);
      check_eq("t3_acc_at_ret", 32'(acc_cnt - ab), 32'h4);
      check_eq("t3_stalled", 32'(m_wait[0]), 32'h1);
      check_eq("t3_rdata", 32'(m_rdata), 32'h1F007);
      p = 1;
      tick();
      check_eq("t3_unstall", 32'(m_wait[0]), 32'h0);
      if (m_rdv[0]) p++;
      for (t = 0; t < 100 && p < 6; t++) begin
         tick();
         if (m_rdv[0]) p++;
      end
      check_eq("t3_six_ret", 32'(p), 32'h6);
      check_eq("t3_drain_grant", 32'(grant), 32'h1);
      check_eq("t3_drain_wait", 32'(m_wait), 32'hF);
      tick();
      check_eq("t3_released", 32'(grant), 32'h0);
      check_eq("t3_rdv_owner", 32'(rdv_cnt[0] - r0), 32'h6);
      check_eq("t3_rdv_others", 32'(rdv_cnt[1] + rdv_cnt[2] + rdv_cnt[3] - ro), 32'h0);
      check_eq("t3_max_pend", 32'(max_out), 32'h4);

      // engine 3 drops with 2 reads pending while engine 1 waits
      r3 = 0;
      rd_req[3] += 2;
      for (t = 0; t < 20 && grant != 4'b1000; t++) tick();
      check_eq("t4_grant3", 32'(grant), 32'h8);
      wr_req[1] += 1;
      for (t = 0; t < 60 && r3 < 2; t++) begin
         tick();
         if (m_rdv[3]) r3++;
      end
      check_eq("t4_two_ret", 32'(r3), 32'h2);
      check_eq("t4_hold", 32'(grant), 32'h8);
      check_eq("t4_e1_wait", 32'(m_wait[1]), 32'h1);
      tick();
      check_eq("t4_gap", 32'(grant), 32'h0);
      tick();
      check_eq("t4_regrant", 32'(grant), 32'h2);
      for (t = 0; t < 20 && !(wr_done[1] == 2 && grant == '0); t++) tick();
      check_eq("t4_done", 32'(wr_done[1] == 2 && grant == '0), 32'h1);

      // spurious return while idle, then reset mid-read
      force_rdv = 1'b1;
      #1;
      check_eq("t5_no_rdv", 32'(m_rdv), 32'h0);
      tick();
      force_rdv = 1'b0;
      check_eq("t5_err_set", 32'(err), 32'h1);
      repeat (3) tick();
      check_eq("t5_err_sticky", 32'(err), 32'h1);
      reset = 1'b0;
      tick();
      check_eq("t5_err_clr", 32'(err), 32'h0);
      reset = 1'b1;
      rd_req[2] += 1;
      for (t = 0; t < 20 && rd_done[2] != 2; t++) tick();
      check_eq("t5_rd_issued", 32'(rd_done[2]), 32'h2);
      reset = 1'b0;
      tick();
      check_eq("t5_mid_grant", 32'(grant), 32'h0);
      check_eq("t5_mid_wait", 32'(m_wait), 32'hF);
      reset = 1'b1;
      r2 = rdv_cnt[2];
      for (t = 0; t < 30 && !err; t++) tick();
      tick();
      check_eq("t5_late_err", 32'(err), 32'h1);
      check_eq("t5_late_rdv", 32'(rdv_cnt[2] - r2), 32'h0);
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // two persistent writers
      gb = gq.size(); wb = waddr_q.size();
      wr_req[0] += 20; wr_req[2] += 20;
      for (t = 0; t < 300 && !(wr_done[0] == 20 && wr_done[2] == 21 && grant == '0); t++) tick();
      check_eq("t6_done", 32'(wr_done[0] == 20 && wr_done[2] == 21 && grant == '0), 32'h1);
      check_eq("t6_w7", 32'(wat(wb + 7)), 32'(A0));
`ifdef ARB_HOLD_LIMIT_EN
      check_eq("t6_w8", 32'(wat(wb + 8)), 32'(A2));
      check_eq("t6_ngrants", 32'(gq.size() - gb), 32'h6);
      for (int i = 0; i < 6; i++) check_eq("t6_alt", 32'(gat(gb + i)), (i % 2 == 0) ? 32'h1 : 32'h4);
`else
      check_eq("t6_w8", 32'(wat(wb + 8)), 32'(A0));
      check_eq("t6_w19", 32'(wat(wb + 19)), 32'(A0));
      check_eq("t6_ngrants", 32'(gq.size() - gb), 32'h2);
      check_eq("t6_g0", 32'(gat(gb)), 32'h1);
      check_eq("t6_g1", 32'(gat(gb + 1)), 32'h4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one SDRAM controller port (Avalon-MM style: read/write/address/writedata, waitrequest/readdatavalid/readdata) between NUM_REQ segment engines.
- Sits between the segment engines' SDRAM master ports and the single SDRAM controller.
- Round-robin grant; a grant is held until the owner has gone idle and all of its outstanding reads have returned, so read data can never be steered to the wrong engine.

Parameters:
- NUM_REQ, 4: number of requesting segment engines (2..8).
- ADDR_WID, 5: SDRAM segment address width (FRAG_BITS+FRAG_WID).
- DATA_WID, 21: segment word width (2+IDWID+MASKWID+KWID+PRIOWID).
- MAX_PEND, 4: maximum outstanding accepted reads per grant (1..15).
- HOLD_LIMIT, 8: commands per grant before forced release (used only with the optional feature).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-low reset.
- i_m_read, input, NUM_REQ: per-engine read request.
- i_m_write, input, NUM_REQ: per-engine write request.
- i_m_address, input, NUM_REQ*ADDR_WID: per-engine address; engine k occupies slice [k*ADDR_WID +: ADDR_WID].
- i_m_writedata, input, NUM_REQ*DATA_WID: per-engine write data, sliced the same way.
- o_m_waitrequest, output, NUM_REQ: per-engine waitrequest.
- o_m_readdatavalid, output, NUM_REQ: per-engine read data valid.
- o_m_readdata, output, DATA_WID: i_sdram_readdata broadcast to all engines.
- o_sdram_read, output, 1: read command to controller.
- o_sdram_write, output, 1: write command to controller.
- o_sdram_address, output, ADDR_WID: address to controller.
- o_sdram_writedata, output, DATA_WID: write data to controller.
- i_sdram_waitrequest, input, 1: controller stall.
- i_sdram_readdatavalid, input, 1: controller read data valid.
- i_sdram_readdata, input, DATA_WID: controller read data.
- o_grant, output, NUM_REQ: one-hot current owner; zero when idle.
- o_err_spurious, output, 1: sticky flag, readdatavalid received with no read pending.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; o_grant=0; pending=0; round-robin pointer=0; o_err_spurious=0.
  - o_m_waitrequest=all ones; o_m_readdatavalid=0; o_sdram_read=0; o_sdram_write=0.
  - Reset mid-operation drops the grant immediately. Read returns still in flight are then spurious and set o_err_spurious.
- Request vector: req[k] = i_m_read[k] | i_m_write[k].
- State IDLE:
  - If req is nonzero, select the first set bit searching from pointer upward, with wrap-around.
  - Register the winner into o_grant and set pointer = winner+1 (mod NUM_REQ).
  - Go to GRANT. Arbitration latency is 1 cycle: a request seen at edge n is first forwarded at edge n+1.
- State GRANT:
  - Owner's read/write/address/writedata are muxed combinationally to the SDRAM port.
  - Owner's waitrequest = i_sdram_waitrequest, or 1 when blocked.
  - Non-owners always see waitrequest=1.
  - Blocked means i_m_read[owner] and pending==MAX_PEND. While blocked, o_sdram_read is forced to 0; writes are still forwarded.
  - Read accepted = o_sdram_read & !i_sdram_waitrequest: pending+1.
  - i_sdram_readdatavalid with pending>0: pending-1.
  - Accept and return in the same cycle: pending unchanged.
  - Owner with req[owner]==0: go to IDLE if pending==0, otherwise go to DRAIN.
- State DRAIN:
  - No commands are forwarded; every o_m_waitrequest=1.
  - Readdatavalid is still routed to the owner.
  - When pending reaches 0 (including the decrement this cycle), go to IDLE and clear o_grant the next cycle.
- Readdatavalid routing: o_m_readdatavalid[k] = i_sdram_readdatavalid & o_grant[k] & (pending>0).
- Spurious return: i_sdram_readdatavalid with pending==0 in any state. It is ignored, no engine sees valid, and o_err_spurious is set; only reset clears it.
- Simultaneous requests: round-robin order only. No engine waits more than NUM_REQ-1 grants.
- Idle → re-grant gap: at least 1 cycle.
- All outputs except the combinational mux paths are registered.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - A per-grant counter increments on each accepted command (read or write).
  - On reaching HOLD_LIMIT, the owner is treated as req=0: stall it, then DRAIN/IDLE and re-arbitrate from the pointer.
  - A persistent requester is re-granted only after the other requesters have had their turn.
- Undefined: the counter is absent and an owner may hold the port indefinitely.

Test Plan:
1. Reset held low 3 cycles while i_m_read=4'b1111 → o_grant=0, o_m_waitrequest=4'b1111, o_sdram_read=0. Release reset → o_grant=4'b0001 one cycle later.
2. Engines 1 and 2 each issue one write (addr 5'h03/5'h11, data 21'h0ABCD/21'h15555), then deassert; waitrequest=0 → grant order 0010 then 0100; SDRAM sees two writes with matching addr/data; o_grant returns to 0.
3. Engine 0 issues 6 back-to-back reads, readdatavalid delayed 10 cycles, MAX_PEND=4 → 4 reads accepted; o_m_waitrequest[0]=1 until the first return; all 6 returns reach only o_m_readdatavalid[0]; state DRAIN until pending=0.
4. Engine 3 drops its request with 2 reads pending while engine 1 requests → o_grant stays 4'b1000 until the 2nd readdatavalid; o_grant=4'b0010 two cycles later.
5. i_sdram_readdatavalid pulsed while idle → o_m_readdatavalid=0 and o_err_spurious=1, held until reset.
6. With ARB_HOLD_LIMIT_EN and HOLD_LIMIT=8: engines 0 and 2 requesting continuously → grant alternates after every 8 accepted commands. Without the macro, engine 0 keeps the grant indefinitely.
